// File: rtl/crossbar_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : crossbar_arbiter
// Function : Round-robin per-lane arbiter and registered switch for an N-lane crossbar.
//            Optional macro CROSSBAR_ARB_CONFLICT_CNT_EN enables the denied-request counter.
// Revision : 1.0
// ============================================================================
module crossbar_arbiter #(
  parameter int N  = 5,
  parameter int W  = 8,
  parameter int DW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            io_clk_en,
  input  logic [N-1:0]    io_in_valid,
  input  logic [N*DW-1:0] io_in_dest,
  input  logic [N*W-1:0]  io_in_data,
  output logic [N-1:0]    io_in_ready,
  output logic [N-1:0]    io_out_valid,
  output logic [N*W-1:0]  io_out_data,
  output logic [N*DW-1:0] io_out_src,
  output logic            io_err,
  output logic [15:0]     io_conflict_cnt
);

  localparam logic [DW:0] N_EXT = (DW+1)'(N);

  logic [DW-1:0]   dest [N];
  logic [N-1:0]    illegal;
  logic [N-1:0]    grant;
  logic [N-1:0]    win_found;
  logic [DW-1:0]   win_idx [N];

  logic [DW-1:0]   ptr_q [N];
  logic [DW-1:0]   ptr_d [N];
  logic [N-1:0]    out_valid_q, out_valid_d;
  logic [N*W-1:0]  out_data_q, out_data_d;
  logic [N*DW-1:0] out_src_q, out_src_d;
  logic            err_q, err_d;

  generate
    for (genvar i = 0; i < N; i++) begin : g_req
      assign dest[i]    = io_in_dest[i*DW +: DW];
      assign illegal[i] = ({1'b0, dest[i]} >= N_EXT);
    end
  endgenerate

  // Per-lane scan starting at ptr_j; a requester names one lane so it wins at most one.
  always_comb begin
    grant = '0;
    for (int j = 0; j < N; j++) begin
      win_found[j] = 1'b0;
      win_idx[j]   = '0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = int'(ptr_q[j]) + k;
        if (idx >= N) idx = idx - N;
        if (!win_found[j] && io_in_valid[idx] && (dest[idx] == DW'(j))) begin
          win_found[j] = 1'b1;
          win_idx[j]   = DW'(idx);
          grant[idx]   = 1'b1;
        end
      end
    end
  end

  assign io_in_ready = {N{io_clk_en & ~reset}} & (grant | illegal);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    if (io_clk_en) begin
      err_d = err_q | (|(io_in_valid & illegal));
      for (int j = 0; j < N; j++) begin
        if (win_found[j]) begin
          out_valid_d[j]          = 1'b1;
          out_data_d[j*W +: W]    = io_in_data[int'(win_idx[j])*W +: W];
          out_src_d[j*DW +: DW]   = win_idx[j];
          ptr_d[j]                = (win_idx[j] == DW'(N-1)) ? '0 : win_idx[j] + DW'(1);
        end else begin
          out_valid_d[j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      err_q       <= 1'b0;
      ptr_q       <= '{default: '0};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign io_out_valid = out_valid_q;
  assign io_out_data  = out_data_q;
  assign io_out_src   = out_src_q;
  assign io_err       = err_q;

`ifdef CROSSBAR_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic [16:0] cnt_sum;

  // Denied = valid with a legal lane but not granted; 17-bit sum detects overflow.
  always_comb begin
    cnt_sum = {1'b0, conflict_cnt_q};
    if (io_clk_en) begin
      for (int i = 0; i < N; i++) begin
        cnt_sum = cnt_sum + 17'(io_in_valid[i] & ~illegal[i] & ~grant[i]);
      end
    end
    conflict_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign io_conflict_cnt = conflict_cnt_q;
`else
  assign io_conflict_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/crossbar_arbiter.md
# crossbar_arbiter

Round-robin arbiter and sequencer for the 5-lane 8-bit crossbar datapath. Each requester presents a byte tagged with a destination lane. Per cycle, the block grants at most one requester per output lane and at most one lane per requester, registers the switched data, and honours the shared `io_clk_en` stall. It sits directly in front of the convolution-array operand lanes and replaces the fixed lane-to-lane crossbar wherever sources must share destinations.

## Interface
Parameters:
- `N`, 5: number of requesters and of output lanes.
- `W`, 8: data width per lane.
- `DW`, 3: destination field width; must satisfy 2^DW >= N.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_clk_en`  in  1  global advance enable; when 0 the block holds all state.
- `io_in_valid`  in  N  requester i has a byte to send.
- `io_in_dest`  in  N*DW  destination lane of requester i, in bits [i*DW +: DW].
- `io_in_data`  in  N*W  byte of requester i, in bits [i*W +: W].
- `io_in_ready`  out  N  requester i's byte is consumed this cycle (combinational).
- `io_out_valid`  out  N  output lane j holds a freshly switched byte (registered).
- `io_out_data`  out  N*W  registered data per output lane.
- `io_out_src`  out  N*DW  index of the requester that produced lane j's data (registered).
- `io_err`  out  1  sticky flag: a request named a destination >= N.
- `io_conflict_cnt`  out  16  denied-request counter (see Configuration).

## Operation
- Every output lane j keeps a round-robin pointer `ptr_j` in the range 0..N-1.
- Candidates for lane j: every requester i with `io_in_valid[i]=1` and `dest_i == j`.
- Winner of lane j: the first candidate found by scanning i = `ptr_j`, `ptr_j`+1, ... modulo N.
- A requester has one destination, so it can win at most one lane. Lane arbitrations are independent.
- `io_in_ready[i]` = `io_clk_en` AND (i wins its lane OR `dest_i >= N`).
- Invalid destination: the request is consumed and discarded. No lane is driven. `io_err` is set and stays set until reset.
- Lane j with a winner w, when `io_clk_en=1`:
  - `out_valid_j <= 1`, `out_data_j <= data_w`, `out_src_j <= w`.
  - `ptr_j <= (w+1) mod N`.
- Lane j with no winner, when `io_clk_en=1`: `out_valid_j <= 0`. Data, source and `ptr_j` hold.
- When `io_clk_en=0`: all registers hold, including `io_out_valid`, and `io_in_ready` = 0.
- Requester handshake: a requester must hold valid, dest and data stable until it sees ready. The block never drops a request that has a legal destination.

## Timing
- Arbitration and `io_in_ready` are combinational in cycle t.
- Switched data appears on `io_out_*` at t+1, so latency is one enabled cycle.
- Throughput: up to N bytes per cycle when all destinations are distinct.
- Fairness: a persistent requester on a contended lane is granted within N enabled cycles.
- Reset values: `io_out_valid` = 0, `io_out_data` = 0, `io_out_src` = 0, `io_err` = 0, `io_conflict_cnt` = 0, every `ptr_j` = 0.
- `io_in_ready` = 0 throughout the reset cycle.
- Reset has priority over `io_clk_en`.
- Reset mid-stream: in-flight outputs are cleared. Requesters that never saw ready must re-present.
- Pointer wrap: a grant to requester N-1 sets `ptr_j` to 0.

## Configuration
- Macro `CROSSBAR_ARB_CONFLICT_CNT_EN`.
- Defined: `io_conflict_cnt` is a 16-bit saturating counter. On each enabled cycle it adds the number of requesters with `io_in_valid=1`, a legal destination and `io_in_ready=0`. It saturates at 16'hFFFF.
- Undefined: the counter logic is absent and `io_conflict_cnt` is tied to 0.

## Test plan
- Distinct destinations: requester i sends 8'h10+i to lane 4-i, `io_clk_en=1` -> all ready=1. Next cycle lane 4-i shows 8'h10+i, src=i, and all out_valid=1.
- Contention: requesters 0, 2 and 3 all target lane 1 continuously -> grants rotate 0, 2, 3, 0. Each loser sees ready=0. With the macro defined, the counter grows by 2 per cycle.
- Stall: assert `io_clk_en=0` for 3 cycles mid-contention -> ready=0, outputs and pointers frozen. The rotation resumes exactly where it stopped.
- Invalid destination: requester 1 sends dest=6 -> ready[1]=1, no lane valid, `io_err`=1 until reset.
- Reset mid-operation: assert `reset` while lanes are valid -> next cycle all outputs are 0 and `ptr_j`=0. Requester 4 and requester 0 both targeting lane 2 -> requester 0 wins first.
- Saturation (macro defined): preload the counter to 16'hFFFE and create 2 denials -> the counter reads 16'hFFFF and holds.
